// File: rtl/register_file_pkg.sv
// ============================================================================
// register_file_pkg : shared core widths for decode, register file, write-back
// Rev 1.0
// ============================================================================
`default_nettype none

package register_file_pkg;
  localparam int DATA_W   = 24;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;
endpackage

`default_nettype wire

// File: rtl/register_file_if.sv
// ============================================================================
// register_file_if : read, write-back and reservation bus of the register file
// Rev 1.0
// ============================================================================
`default_nettype none

interface register_file_if #(
  parameter int DATA_W = register_file_pkg::DATA_W,
  parameter int ADDR_W = register_file_pkg::ADDR_W
);
  logic [ADDR_W-1:0] read_index_1;
  logic [ADDR_W-1:0] read_index_2;
  logic [DATA_W-1:0] read_data_1;
  logic [DATA_W-1:0] read_data_2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_index;
  logic [DATA_W-1:0] wr_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_index;
  logic              busy_1;
  logic              busy_2;
  logic              stall;

  modport master (
    output read_index_1, read_index_2, wr_en, wr_index, wr_data, rsv_en, rsv_index,
    input  read_data_1, read_data_2, busy_1, busy_2, stall
  );

  modport slave (
    input  read_index_1, read_index_2, wr_en, wr_index, wr_data, rsv_en, rsv_index,
    output read_data_1, read_data_2, busy_1, busy_2, stall
  );
endinterface

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// reg_scoreboard : one busy bit per register, set on reservation, cleared on write-back
// Rev 1.0
// ============================================================================
`default_nettype none

module reg_scoreboard #(
  parameter int ADDR_W   = register_file_pkg::ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              set_en,
  input  wire logic [ADDR_W-1:0] set_index,
  input  wire logic              clr_en,
  input  wire logic [ADDR_W-1:0] clr_index,
  input  wire logic [ADDR_W-1:0] query_index_1,
  input  wire logic [ADDR_W-1:0] query_index_2,
  output logic                   busy_1,
  output logic                   busy_2
);
  import register_file_pkg::*;

  localparam int c_depth = 2 ** ADDR_W;

  logic [c_depth-1:0] r_busy;
  logic [c_depth-1:0] w_busy_nxt;
  logic               w_set_ok;

  assign w_set_ok = set_en && !((ZERO_REG != 0) && (set_index == '0));

  // Set is applied after clear so a same-index reservation outlives the write-back.
  always_comb begin
    w_busy_nxt = r_busy;
    if (clr_en) w_busy_nxt[clr_index] = 1'b0;
    if (w_set_ok) w_busy_nxt[set_index] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  assign busy_1 = r_busy[query_index_1] && !(clr_en && (clr_index == query_index_1));
  assign busy_2 = r_busy[query_index_2] && !(clr_en && (clr_index == query_index_2));
endmodule

`default_nettype wire

// File: rtl/register_file.sv
// ============================================================================
// register_file : 2-read/1-write register file with write-through bypass and hazard scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module register_file #(
  parameter int DATA_W   = register_file_pkg::DATA_W,
  parameter int ADDR_W   = register_file_pkg::ADDR_W,
  parameter int ZERO_REG = 1
) (
  input wire logic        clk,
  input wire logic        reset,
  register_file_if.slave  rf
);
  import register_file_pkg::*;

  localparam int c_depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [c_depth];
  logic              w_wr_ok;
  logic              w_zero_1;
  logic              w_zero_2;
  logic              w_hit_1;
  logic              w_hit_2;
  logic              w_busy_1;
  logic              w_busy_2;

  assign w_wr_ok = rf.wr_en && !((ZERO_REG != 0) && (rf.wr_index == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < c_depth; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[rf.wr_index] <= rf.wr_data;
    end
  end

  // Hardwired zero takes priority over the bypass path.
  assign w_zero_1 = (ZERO_REG != 0) && (rf.read_index_1 == '0);
  assign w_zero_2 = (ZERO_REG != 0) && (rf.read_index_2 == '0);
  assign w_hit_1  = rf.wr_en && (rf.wr_index == rf.read_index_1);
  assign w_hit_2  = rf.wr_en && (rf.wr_index == rf.read_index_2);

  assign rf.read_data_1 = w_zero_1 ? '0 : (w_hit_1 ? rf.wr_data : r_mem[rf.read_index_1]);
  assign rf.read_data_2 = w_zero_2 ? '0 : (w_hit_2 ? rf.wr_data : r_mem[rf.read_index_2]);

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .set_en        (rf.rsv_en),
    .set_index     (rf.rsv_index),
    .clr_en        (rf.wr_en),
    .clr_index     (rf.wr_index),
    .query_index_1 (rf.read_index_1),
    .query_index_2 (rf.read_index_2),
    .busy_1        (w_busy_1),
    .busy_2        (w_busy_2)
  );

  assign rf.busy_1 = w_busy_1;
  assign rf.busy_2 = w_busy_2;
  assign rf.stall  = w_busy_1 | w_busy_2;
endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
// tb_register_file : directed vector table plus random traffic against an array model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_register_file;
  import register_file_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rf ();

  register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf)
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] m_mem  [NUM_REGS];
  logic              m_busy [NUM_REGS];

  typedef struct {
    logic              rst;
    logic              we;
    logic [ADDR_W-1:0] wi;
    logic [DATA_W-1:0] wd;
    logic              re;
    logic [ADDR_W-1:0] rsi;
    logic [ADDR_W-1:0] r1;
    logic [ADDR_W-1:0] r2;
    logic              chk;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic              b1;
    logic              b2;
    logic              st;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [ADDR_W-1:0] wi,
                       input logic [DATA_W-1:0] wd, input logic re, input logic [ADDR_W-1:0] rsi,
                       input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    @(negedge clk);
    reset           = rst;
    rf.wr_en        = we;
    rf.wr_index     = wi;
    rf.wr_data      = wd;
    rf.rsv_en       = re;
    rf.rsv_index    = rsi;
    rf.read_index_1 = r1;
    rf.read_index_2 = r2;
    #2;
  endtask

  function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] idx);
    if (idx == 0) return '0;
    if (rf.wr_en && rf.wr_index == idx) return rf.wr_data;
    return m_mem[idx];
  endfunction

  function automatic logic exp_busy(input logic [ADDR_W-1:0] idx);
    return m_busy[idx] && !(rf.wr_en && rf.wr_index == idx);
  endfunction

  task automatic check_model();
    logic eb1, eb2;
    eb1 = exp_busy(rf.read_index_1);
    eb2 = exp_busy(rf.read_index_2);
    check("rd1", 32'(rf.read_data_1), 32'(exp_data(rf.read_index_1)));
    check("rd2", 32'(rf.read_data_2), 32'(exp_data(rf.read_index_2)));
    check("busy1", 32'(rf.busy_1), 32'(eb1));
    check("busy2", 32'(rf.busy_2), 32'(eb2));
    check("stall", 32'(rf.stall), 32'(eb1 | eb2));
  endtask

  // Clock edge: commit the current inputs into the model.
  task automatic advance();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (rf.wr_en && rf.wr_index != 0) m_mem[rf.wr_index] = rf.wr_data;
      if (rf.wr_en) m_busy[rf.wr_index] = 1'b0;
      if (rf.rsv_en && rf.rsv_index != 0) m_busy[rf.rsv_index] = 1'b1;
    end
  endtask

  task automatic cycle(input logic rst, input logic we, input logic [ADDR_W-1:0] wi,
                       input logic [DATA_W-1:0] wd, input logic re, input logic [ADDR_W-1:0] rsi,
                       input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    drive(rst, we, wi, wd, re, rsi, r1, r2);
    check_model();
    advance();
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    reset = 1'b1;
    rf.wr_en = 1'b0; rf.wr_index = '0; rf.wr_data = '0;
    rf.rsv_en = 1'b0; rf.rsv_index = '0;
    rf.read_index_1 = '0; rf.read_index_2 = '0;

    //         rst we wi  wd           re rsi r1  r2  chk d1           d2           b1 b2 st
    vecs[0]  = '{1, 0, 0,  24'h000000, 0, 0,  3,  17, 0, 24'h000000, 24'h000000, 0, 0, 0};
    vecs[1]  = '{0, 0, 0,  24'h000000, 0, 0,  3,  17, 1, 24'h000000, 24'h000000, 0, 0, 0};
    vecs[2]  = '{0, 1, 5,  24'hABCDEF, 0, 0,  5,  3,  1, 24'hABCDEF, 24'h000000, 0, 0, 0};
    vecs[3]  = '{0, 0, 0,  24'h000000, 0, 0,  5,  5,  1, 24'hABCDEF, 24'hABCDEF, 0, 0, 0};
    vecs[4]  = '{0, 1, 0,  24'h123456, 1, 0,  0,  0,  1, 24'h000000, 24'h000000, 0, 0, 0};
    vecs[5]  = '{0, 0, 0,  24'h000000, 0, 0,  0,  0,  1, 24'h000000, 24'h000000, 0, 0, 0};
    vecs[6]  = '{0, 0, 0,  24'h000000, 1, 9,  0,  9,  1, 24'h000000, 24'h000000, 0, 0, 0};
    vecs[7]  = '{0, 0, 0,  24'h000000, 0, 0,  9,  9,  1, 24'h000000, 24'h000000, 1, 1, 1};
    vecs[8]  = '{0, 1, 9,  24'h000042, 0, 0,  3,  9,  1, 24'h000000, 24'h000042, 0, 0, 0};
    vecs[9]  = '{0, 0, 0,  24'h000000, 0, 0,  3,  9,  1, 24'h000000, 24'h000042, 0, 0, 0};
    vecs[10] = '{0, 1, 12, 24'h777777, 1, 12, 12, 3,  1, 24'h777777, 24'h000000, 0, 0, 0};
    vecs[11] = '{0, 0, 0,  24'h000000, 0, 0,  12, 3,  1, 24'h777777, 24'h000000, 1, 0, 1};
    vecs[12] = '{0, 1, 7,  24'h0F0F0F, 1, 7,  7,  12, 1, 24'h0F0F0F, 24'h777777, 0, 1, 1};
    vecs[13] = '{1, 1, 7,  24'h555555, 1, 3,  7,  7,  1, 24'h555555, 24'h555555, 0, 0, 0};
    vecs[14] = '{0, 0, 0,  24'h000000, 0, 0,  7,  3,  1, 24'h000000, 24'h000000, 0, 0, 0};
    vecs[15] = '{0, 0, 0,  24'h000000, 0, 0,  12, 5,  1, 24'h000000, 24'h000000, 0, 0, 0};

    foreach (vecs[v]) begin
      drive(vecs[v].rst, vecs[v].we, vecs[v].wi, vecs[v].wd, vecs[v].re, vecs[v].rsi,
            vecs[v].r1, vecs[v].r2);
      if (vecs[v].chk) begin
        check($sformatf("vec%0d_rd1", v), 32'(rf.read_data_1), 32'(vecs[v].d1));
        check($sformatf("vec%0d_rd2", v), 32'(rf.read_data_2), 32'(vecs[v].d2));
        check($sformatf("vec%0d_busy1", v), 32'(rf.busy_1), 32'(vecs[v].b1));
        check($sformatf("vec%0d_busy2", v), 32'(rf.busy_2), 32'(vecs[v].b2));
        check($sformatf("vec%0d_stall", v), 32'(rf.stall), 32'(vecs[v].st));
      end
      advance();
    end

    // Re-reserving a busy register keeps one outstanding writer; one write-back frees it.
    cycle(0, 0, 0,  '0,          1, 20, 20, 21);
    cycle(0, 0, 0,  '0,          1, 20, 20, 20);
    cycle(0, 0, 0,  '0,          0, 0,  20, 21);
    check("rersv_busy1", 32'(rf.busy_1), 32'd1);
    cycle(0, 1, 20, 24'hC0FFEE,  1, 21, 20, 21);
    cycle(0, 0, 0,  '0,          0, 0,  20, 21);
    check("rersv_cleared", 32'(rf.busy_1), 32'd0);
    check("rersv_other", 32'(rf.busy_2), 32'd1);
    check("rersv_data", 32'(rf.read_data_1), 32'hC0FFEE);

    // Random traffic, biased toward a few low indices to provoke hazards and bypasses.
    for (int n = 0; n < 600; n++) begin
      logic [ADDR_W-1:0] wi, rsi, r1, r2;
      wi  = ADDR_W'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NUM_REGS - 1));
      rsi = ADDR_W'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NUM_REGS - 1));
      r1  = ADDR_W'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, NUM_REGS - 1));
      r2  = ADDR_W'($urandom_range(0, 3) == 0 ? 32'(r1) : $urandom_range(0, 7));
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 1), wi,
            DATA_W'($urandom), ($urandom_range(0, 4) < 2), rsi, r1, r2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
